// File: rtl/alu_seq_exec.sv
// alu_seq_exec: RV32I integer ALU decode/execute unit with valid/ready
// handshakes on both sides. Non-shift operations complete one cycle after
// acceptance. Shifts run serially, one bit per cycle, so a shift by shamt
// completes shamt+1 cycles after acceptance.
//
// Ports:
//   clk, rst           rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  request handshake (in_ready high only when idle)
//   ALUOp              00 add, 01 sub, 10 R-type, 11 I-type
//   funct3, funct7     instruction function fields (funct7 = imm[11:5] for I-type)
//   op_a, op_b         operands; the shift amount is op_b[SHW-1:0]
//   out_valid/out_ready result handshake
//   result, zero       ALU result and (result == 0)
//   illegal            unsupported funct combination
//   alu_ctrl           decoded operation code, for trace
module alu_seq_exec #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            illegal,
    output logic [3:0]      alu_ctrl
);

    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SUB  = 4'b0001;
    localparam logic [3:0] CTRL_AND  = 4'b0010;
    localparam logic [3:0] CTRL_OR   = 4'b0011;
    localparam logic [3:0] CTRL_XOR  = 4'b0100;
    localparam logic [3:0] CTRL_SLL  = 4'b0101;
    localparam logic [3:0] CTRL_SRL  = 4'b0110;
    localparam logic [3:0] CTRL_SRA  = 4'b0111;
    localparam logic [3:0] CTRL_SLT  = 4'b1000;
    localparam logic [3:0] CTRL_SLTU = 4'b1001;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    // funct3 -> operation for the base (funct7 = 0) encodings
    function automatic logic [3:0] base_map(input logic [2:0] f3);
        logic [3:0] c;
        case (f3)
            3'b000:  c = CTRL_ADD;
            3'b001:  c = CTRL_SLL;
            3'b010:  c = CTRL_SLT;
            3'b011:  c = CTRL_SLTU;
            3'b100:  c = CTRL_XOR;
            3'b101:  c = CTRL_SRL;
            3'b110:  c = CTRL_OR;
            3'b111:  c = CTRL_AND;
            default: c = CTRL_ADD;
        endcase
        return c;
    endfunction

    // Returns {illegal, alu_ctrl}; alu_ctrl is forced to ADD when illegal
    function automatic logic [4:0] decode_op(input logic [1:0] aluop,
                                             input logic [2:0] f3,
                                             input logic [6:0] f7);
        logic       ill;
        logic [3:0] c;
        ill = 1'b0;
        c   = base_map(f3);
        case (aluop)
            2'b00: c = CTRL_ADD;
            2'b01: c = CTRL_SUB;
            2'b10: begin
                if (f7 == F7_BASE) begin
                    c = base_map(f3);
                end else if ((f7 == F7_ALT) && (f3 == 3'b000)) begin
                    c = CTRL_SUB;
                end else if ((f7 == F7_ALT) && (f3 == 3'b101)) begin
                    c = CTRL_SRA;
                end else begin
                    ill = 1'b1;
                end
            end
            2'b11: begin
                // Immediate forms: funct7 only qualifies the shift encodings
                if ((f3 == 3'b001) && (f7 != F7_BASE)) begin
                    ill = 1'b1;
                end else if ((f3 == 3'b101) && (f7 == F7_ALT)) begin
                    c = CTRL_SRA;
                end else if ((f3 == 3'b101) && (f7 != F7_BASE)) begin
                    ill = 1'b1;
                end else begin
                    c = base_map(f3);
                end
            end
            default: ill = 1'b1;
        endcase
        if (ill) begin
            c = CTRL_ADD;
        end else begin
            c = c;
        end
        return {ill, c};
    endfunction

    state_e          state_r;
    logic            in_ready_r;
    logic            out_valid_r;
    logic [XLEN-1:0] result_r;
    logic            zero_r;
    logic            illegal_r;
    logic [3:0]      alu_ctrl_r;
    logic [XLEN-1:0] shift_val_r;
    logic [SHW-1:0]  count_r;
    logic [3:0]      shift_op_r;

    logic [4:0]      dec_s;
    logic            dec_illegal_s;
    logic [3:0]      dec_ctrl_s;
    logic            is_shift_s;
    logic [SHW-1:0]  shamt_s;
    logic [XLEN-1:0] exec_result_s;
    logic [XLEN-1:0] fin_result_s;
    logic [XLEN-1:0] shift_next_s;

    // Decode the request fields
    always_comb begin
        dec_s         = decode_op(ALUOp, funct3, funct7);
        dec_illegal_s = dec_s[4];
        dec_ctrl_s    = dec_s[3:0];
        shamt_s       = op_b[SHW-1:0];
        is_shift_s    = (dec_ctrl_s == CTRL_SLL) || (dec_ctrl_s == CTRL_SRL) ||
                        (dec_ctrl_s == CTRL_SRA);
    end

    // Single-cycle execute; a shift yields op_a, which is the final answer
    // when shamt is zero (non-zero shifts go through the serial path instead)
    always_comb begin
        exec_result_s = {XLEN{1'b0}};
        case (dec_ctrl_s)
            CTRL_ADD:  exec_result_s = op_a + op_b;
            CTRL_SUB:  exec_result_s = op_a - op_b;
            CTRL_AND:  exec_result_s = op_a & op_b;
            CTRL_OR:   exec_result_s = op_a | op_b;
            CTRL_XOR:  exec_result_s = op_a ^ op_b;
            CTRL_SLT:  exec_result_s = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            CTRL_SLTU: exec_result_s = {{(XLEN-1){1'b0}}, (op_a < op_b)};
            CTRL_SLL,
            CTRL_SRL,
            CTRL_SRA:  exec_result_s = op_a;
            default:   exec_result_s = {XLEN{1'b0}};
        endcase
        if (dec_illegal_s) begin
            fin_result_s = {XLEN{1'b0}};
        end else begin
            fin_result_s = exec_result_s;
        end
    end

    // One-bit step of the serial shifter
    always_comb begin
        case (shift_op_r)
            CTRL_SLL: shift_next_s = {shift_val_r[XLEN-2:0], 1'b0};
            CTRL_SRL: shift_next_s = {1'b0, shift_val_r[XLEN-1:1]};
            CTRL_SRA: shift_next_s = {shift_val_r[XLEN-1], shift_val_r[XLEN-1:1]};
            default:  shift_next_s = shift_val_r;
        endcase
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            result_r    <= {XLEN{1'b0}};
            zero_r      <= 1'b0;
            illegal_r   <= 1'b0;
            alu_ctrl_r  <= 4'b0000;
            shift_val_r <= {XLEN{1'b0}};
            count_r     <= {SHW{1'b0}};
            shift_op_r  <= 4'b0000;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (in_valid) begin
                        in_ready_r <= 1'b0;
                        if (!dec_illegal_s && is_shift_s && (shamt_s != {SHW{1'b0}})) begin
                            state_r     <= ST_BUSY;
                            shift_val_r <= op_a;
                            count_r     <= shamt_s;
                            shift_op_r  <= dec_ctrl_s;
                        end else begin
                            state_r     <= ST_DONE;
                            out_valid_r <= 1'b1;
                            result_r    <= fin_result_s;
                            zero_r      <= (fin_result_s == {XLEN{1'b0}});
                            illegal_r   <= dec_illegal_s;
                            alu_ctrl_r  <= dec_ctrl_s;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    shift_val_r <= shift_next_s;
                    count_r     <= count_r - {{(SHW-1){1'b0}}, 1'b1};
                    // Last bit shifted this edge: publish the result now
                    if (count_r == {{(SHW-1){1'b0}}, 1'b1}) begin
                        state_r     <= ST_DONE;
                        out_valid_r <= 1'b1;
                        result_r    <= shift_next_s;
                        zero_r      <= (shift_next_s == {XLEN{1'b0}});
                        illegal_r   <= 1'b0;
                        alu_ctrl_r  <= shift_op_r;
                    end else begin
                        state_r <= ST_BUSY;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_r     <= ST_IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign illegal   = illegal_r;
    assign alu_ctrl  = alu_ctrl_r;

endmodule
